board_renderer: RTL and testbench
=================================

# board_renderer

Draws the 10x20 Tetris playfield into the 160x120, 9-bit-colour VGA frame buffer. On a `start` pulse it scans the board RAM cell by cell. Each cell code maps through a fixed palette. The block emits one pixel write per cycle on the `x`/`y`/`color`/`write` inputs of `vga_adapter`, sitting directly upstream of it. Game logic owns the board RAM and pulses `start` whenever the board changes.

## Interface
Parameters:
- `BOARD_W`, 10: cells per row.
- `BOARD_H`, 20: cell rows.
- `CELL`, 5: cell edge in pixels (square).
- `X0`, 55: pixel x of the board's left edge.
- `Y0`, 10: pixel y of the board's top edge.
- `BG_COLOR`, 9'o000: colour of empty cells (code 0).
- `EDGE_COLOR`, 9'o222: outline colour for non-empty cells.

Ports:
- `CLOCK_50`  in  1: single clock; all logic on its rising edge.
- `reset`  in  1: synchronous, active-high reset.
- `start`  in  1: request a full redraw; sampled only in IDLE.
- `cell_addr`  out  8: board RAM read address, row*BOARD_W + col.
- `cell_data`  in  3: board RAM read data; valid one cycle after `cell_addr` is presented (registered RAM).
- `x`  out  8: pixel column to `vga_adapter`.
- `y`  out  7: pixel row to `vga_adapter`.
- `color`  out  9: pixel colour, RGB 3:3:3.
- `write`  out  1: pixel write strobe.
- `busy`  out  1: high while a frame is being drawn.
- `done`  out  1: one-cycle pulse when the frame completes.

## Operation
- States and transitions:
  - IDLE: go to FETCH on `start`.
  - FETCH: 1 cycle; `cell_addr` shows the current cell.
  - LATCH: 1 cycle; `cell_data` captured into `cell_reg`.
  - DRAW: CELL*CELL cycles, one pixel per cycle.
  - After DRAW: go to FETCH for the next cell, or to DONE after the last cell.
  - DONE: 1 cycle, then IDLE.
- Cell order is col fastest, then row, starting at (row 0, col 0) top-left. Pixel order inside a cell is px fastest, then py.
- Counters:
  - `col` 0..BOARD_W-1, wraps to 0 and increments `row`.
  - `row` 0..BOARD_H-1.
  - `px` and `py` 0..CELL-1, both wrap to 0.
- Arithmetic:
  - `x` = X0 + col*CELL + px, truncated to 8 bits.
  - `y` = Y0 + row*CELL + py, truncated to 7 bits.
  - With defaults the maximum is x=104, y=109, so no truncation occurs.
- Palette for codes 1..7: 9'o077 cyan, 9'o770 yellow, 9'o507 purple, 9'o070 green, 9'o700 red, 9'o007 blue, 9'o740 orange.
- Colour selection:
  - Code 0: every pixel is BG_COLOR.
  - Codes 1..7: pixels with px==0, py==0, px==CELL-1 or py==CELL-1 are EDGE_COLOR; interior pixels use the palette.
- `write`=1 exactly in DRAW. When `write`=0, `x`, `y` and `color` are forced to 0.
- `x`, `y`, `color`, `write`, `busy`, `done`, `cell_addr` depend only on registered state; no combinational path from `start` or `cell_data`.
- `cell_addr` holds the current cell index in every state. It is 0 in IDLE.
- `start` outside IDLE, including during DONE, is ignored. No queuing.

## Timing
- Reset (synchronous): state=IDLE, all counters 0, `cell_reg`=0, and every output 0 (`write`, `busy`, `done`, `x`, `y`, `color`, `cell_addr`).
- Reset asserted mid-frame: the frame is abandoned. Next cycle is IDLE with all outputs 0, and no `done` pulse.
- Cycle numbering, with `start` sampled high at edge 0 in IDLE:
  - cycles 1..27: cell 0, i.e. FETCH (cycle 1), LATCH (cycle 2), DRAW (cycles 3..27).
  - general rule: cell n occupies cycles 27n+1 .. 27n+27.
  - `busy`=1 from cycle 1 through cycle 5400.
  - cycle 5401: DONE, with `done`=1 and `busy`=0.
  - cycle 5402: IDLE; a `start` sampled here begins a new frame.
- Exactly BOARD_W*BOARD_H*CELL*CELL = 5000 writes per frame. `write` deasserts for exactly 2 cycles between cells.
- `cell_data` is sampled only at the end of LATCH. Board changes after that edge do not affect the cell being drawn.

## Test plan
- Reset, then idle with no `start` → all outputs 0 indefinitely; `start` held high during reset → no frame begins.
- All-zero board, `start` pulse:
  - 5000 writes, all `color`=9'o000.
  - first write x=55, y=10 at cycle 3; last write x=104, y=109 at cycle 5400.
  - `done` at cycle 5401 only.
- Cell (row 0, col 0)=1, all other cells 0:
  - writes at cycles 3..27 have colour EDGE_COLOR on the 16 perimeter pixels and 9'o077 on the 9 interior pixels (x 56..58, y 11..13).
  - `cell_addr`=1 at cycle 28.
- Cell 199 (row 19, col 9)=7 → cycles 5376..5400 write x 100..104, y 105..109; interior 9'o740, perimeter EDGE_COLOR.
- `start` re-pulsed at cycles 100 and 5401 → ignored; exactly one `done` pulse. `start` at cycle 5402 → new frame, `busy`=1 at cycle 5403.
- `reset` asserted at cycle 1000 → `write`/`busy`=0 at cycle 1001, no `done`. Fresh `start` afterwards → full 5000-write frame from x=55, y=10.

Source files
------------

// File: rtl/board_renderer.sv
// Scans the 10x20 board RAM and paints each cell as a CELL x CELL block of pixel writes for vga_adapter.
// Per cell: FETCH, LATCH, then CELL*CELL DRAW cycles with one write each; no backpressure, start is ignored while busy.
module board_renderer #(
  parameter int         BOARD_W    = 10,
  parameter int         BOARD_H    = 20,
  parameter int         CELL       = 5,
  parameter int         X0         = 55,
  parameter int         Y0         = 10,
  parameter logic [8:0] BG_COLOR   = 9'o000,
  parameter logic [8:0] EDGE_COLOR = 9'o222
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic       start,
  output logic [7:0] cell_addr,
  input  logic [2:0] cell_data,
  output logic [7:0] x,
  output logic [6:0] y,
  output logic [8:0] color,
  output logic       write,
  output logic       busy,
  output logic       done
);

  localparam int CW = (BOARD_W > 1) ? $clog2(BOARD_W) : 1;
  localparam int RW = (BOARD_H > 1) ? $clog2(BOARD_H) : 1;
  localparam int PW = (CELL > 1)    ? $clog2(CELL)    : 1;

  localparam logic [CW-1:0] COL_LAST = CW'(BOARD_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(BOARD_H - 1);
  localparam logic [PW-1:0] PIX_LAST = PW'(CELL - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_LATCH,
    S_DRAW,
    S_DONE
  } state_t;

  state_t        r_state;
  state_t        w_next;
  logic [CW-1:0] r_col;
  logic [RW-1:0] r_row;
  logic [PW-1:0] r_px;
  logic [PW-1:0] r_py;
  logic [2:0]    r_cell;

  logic          w_px_last;
  logic          w_py_last;
  logic          w_col_last;
  logic          w_row_last;
  logic          w_edge;
  logic [8:0]    w_pix_color;
  logic [7:0]    w_x;
  logic [6:0]    w_y;

  function automatic logic [8:0] palette(input logic [2:0] code);
    case (code)
      3'd1:    palette = 9'o077;
      3'd2:    palette = 9'o770;
      3'd3:    palette = 9'o507;
      3'd4:    palette = 9'o070;
      3'd5:    palette = 9'o700;
      3'd6:    palette = 9'o007;
      3'd7:    palette = 9'o740;
      default: palette = BG_COLOR;
    endcase
  endfunction

  assign w_px_last  = (r_px == PIX_LAST);
  assign w_py_last  = (r_py == PIX_LAST);
  assign w_col_last = (r_col == COL_LAST);
  assign w_row_last = (r_row == ROW_LAST);

  assign w_edge      = (r_px == '0) || (r_py == '0) || w_px_last || w_py_last;
  assign w_pix_color = (r_cell == 3'd0) ? BG_COLOR :
                       (w_edge ? EDGE_COLOR : palette(r_cell));

  assign w_x = 8'(X0 + int'(r_col) * CELL + int'(r_px));
  assign w_y = 7'(Y0 + int'(r_row) * CELL + int'(r_py));

  // Counters sit at zero in IDLE, so the address reads 0 there without a mux.
  assign cell_addr = 8'(int'(r_row) * BOARD_W + int'(r_col));

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    write  = 1'b0;
    busy   = 1'b0;
    done   = 1'b0;
    x      = '0;
    y      = '0;
    color  = '0;
    case (r_state)
      S_IDLE: begin
        if (start) w_next = S_FETCH;
      end
      S_FETCH: begin
        busy   = 1'b1;
        w_next = S_LATCH;
      end
      S_LATCH: begin
        busy   = 1'b1;
        w_next = S_DRAW;
      end
      S_DRAW: begin
        busy  = 1'b1;
        write = 1'b1;
        x     = w_x;
        y     = w_y;
        color = w_pix_color;
        if (w_px_last && w_py_last) begin
          w_next = (w_col_last && w_row_last) ? S_DONE : S_FETCH;
        end
      end
      S_DONE: begin
        done   = 1'b1;
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      r_col  <= '0;
      r_row  <= '0;
      r_px   <= '0;
      r_py   <= '0;
      r_cell <= '0;
    end else begin
      case (r_state)
        S_LATCH: r_cell <= cell_data;
        S_DRAW: begin
          if (!w_px_last) begin
            r_px <= r_px + 1'b1;
          end else begin
            r_px <= '0;
            if (!w_py_last) begin
              r_py <= r_py + 1'b1;
            end else begin
              r_py <= '0;
              // Last cell wraps both counters so the next frame starts at (0,0).
              if (w_col_last) begin
                r_col <= '0;
                r_row <= w_row_last ? '0 : r_row + 1'b1;
              end else begin
                r_col <= r_col + 1'b1;
              end
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_board_renderer.sv
// Directed bench for board_renderer: registered board RAM model plus a per-cycle frame timing model.
module tb_board_renderer;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [7:0] cell_addr;
  logic [2:0] cell_data;
  logic [7:0] x;
  logic [6:0] y;
  logic [8:0] color;
  logic       write;
  logic       busy;
  logic       done;

  logic [2:0] board [0:199];
  logic [2:0] snap  [0:199];

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  board_renderer dut (
    .CLOCK_50  (clk),
    .reset     (reset),
    .start     (start),
    .cell_addr (cell_addr),
    .cell_data (cell_data),
    .x         (x),
    .y         (y),
    .color     (color),
    .write     (write),
    .busy      (busy),
    .done      (done)
  );

  always @(posedge clk) cell_data <= (cell_addr < 8'd200) ? board[cell_addr] : 3'd0;

  function automatic logic [8:0] pal(input logic [2:0] code);
    case (code)
      3'd1:    pal = 9'o077;
      3'd2:    pal = 9'o770;
      3'd3:    pal = 9'o507;
      3'd4:    pal = 9'o070;
      3'd5:    pal = 9'o700;
      3'd6:    pal = 9'o007;
      3'd7:    pal = 9'o740;
      default: pal = 9'o000;
    endcase
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_idle(input string tag);
    check(tag, {write, busy, done, x, y, color, cell_addr}, 64'd0);
  endtask

  // Starts a frame from an idle cycle and checks every cycle through the IDLE cycle after DONE.
  task automatic run_frame(input int rs_a, input int rs_b, input bit mutate);
    int writes;
    int dones;
    writes = 0;
    dones  = 0;
    for (int i = 0; i < 200; i++) snap[i] = board[i];
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 1; c <= 5402; c++) begin
      logic       e_w, e_b, e_d;
      logic [7:0] e_x;
      logic [6:0] e_y;
      logic [8:0] e_c;
      logic [7:0] e_a;
      int n, k, p, px, py;
      e_w = 0; e_b = 0; e_d = 0; e_x = 0; e_y = 0; e_c = 0; e_a = 0;
      if (c <= 5400) begin
        n   = (c - 1) / 27;
        k   = (c - 1) % 27;
        e_b = 1'b1;
        e_a = 8'(n);
        if (k >= 2) begin
          p   = k - 2;
          px  = p % 5;
          py  = p / 5;
          e_w = 1'b1;
          e_x = 8'(55 + (n % 10) * 5 + px);
          e_y = 7'(10 + (n / 10) * 5 + py);
          if (snap[n] == 3'd0)                               e_c = 9'o000;
          else if (px == 0 || py == 0 || px == 4 || py == 4) e_c = 9'o222;
          else                                               e_c = pal(snap[n]);
        end
      end else if (c == 5401) begin
        e_d = 1'b1;
      end
      check("pix", {write, busy, done, x, y, color}, {e_w, e_b, e_d, e_x, e_y, e_c});
      if (c != 5401) check("addr", cell_addr, e_a);
      writes += int'(write);
      dones  += int'(done);
      start = (c == rs_a) || (c == rs_b);
      if (mutate && c == 10) board[0] = 3'd5;
      if (c < 5402) tick();
    end
    check("nwrites", writes, 5000);
    check("ndone", dones, 1);
  endtask

  initial begin
    for (int i = 0; i < 200; i++) board[i] = 3'd0;
    reset = 1'b1;
    start = 1'b1;
    tick();
    tick();
    tick();
    check_idle("in_reset");
    reset = 1'b0;
    start = 1'b0;
    for (int i = 0; i < 20; i++) begin
      check_idle("idle");
      tick();
    end

    // All-empty board.
    run_frame(0, 0, 1'b0);

    // Cyan top-left cell; board RAM changes after the cell is latched.
    board[0] = 3'd1;
    run_frame(0, 0, 1'b1);
    board[0] = 3'd0;

    // Mixed board, ignored start pulses mid-frame and in DONE.
    board[0]   = 3'd2;
    board[37]  = 3'd3;
    board[104] = 3'd4;
    board[150] = 3'd6;
    board[199] = 3'd7;
    run_frame(100, 5401, 1'b0);

    // Start in the IDLE cycle after DONE begins a new frame.
    start = 1'b1;
    tick();
    start = 1'b0;
    check("restart_busy", busy, 1);
    for (int i = 0; i < 999; i++) tick();

    // Reset asserted at frame cycle 1000.
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_idle("mid_reset");
    for (int i = 0; i < 30; i++) begin
      tick();
      check_idle("post_reset");
    end

    board[0] = 3'd1;
    run_frame(0, 0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
